pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL take parameter REG_SEL_W, default 3: width of the register-select fields.
REQ-002 SHALL take parameter DEPTH, default 3: number of scoreboard slots, from execute (slot 0) through writeback (slot DEPTH-1); legal range 2..6.
REQ-003 SHALL take parameter RF_BYPASS, default 1: when 1, the register file writes before it reads, so slot DEPTH-1 is excluded from hazard checks.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 dec_valid  in  1  decode holds a real instruction.
REQ-007 dec_rs_sel, dec_rt_sel  in  REG_SEL_W  source registers read in decode.
REQ-008 dec_rs_used, dec_rt_used  in  1  the matching source is actually read.
REQ-009 dec_wr_en  in  1  decode instruction writes a register; dec_wr_sel  in  REG_SEL_W  its destination.
REQ-010 dec_halt  in  1  decode instruction is HALT.
REQ-011 exe_flush  in  1  branch/jump taken in execute; the younger fetch and decode instructions are wrong-path.
REQ-012 ftch_dec_en  out  1  enable for the fetch/decode pipeline register and the PC.
REQ-013 ftch_dec_flush  out  1  load a bubble into the fetch/decode register.
REQ-014 exe_bubble  out  1  execute receives a bubble this cycle (control signals zeroed).
REQ-015 inflight  out  clog2(DEPTH+1)  count of valid scoreboard slots.
REQ-016 halt_done  out  1  pipeline has drained after HALT.
REQ-017 err  out  1  illegal condition seen; sticky.

Function
REQ-018 Each slot SHALL hold {valid, wr_en, wr_sel}.
REQ-019 Every cycle in which state is not HALTED, slot[i] SHALL load slot[i-1] for i=1..DEPTH-1, and slot[DEPTH-1] SHALL retire.
REQ-020 hazard SHALL be 1 when, for any checked slot i, valid & wr_en & (wr_sel==rs_sel & rs_used | wr_sel==rt_sel & rt_used), and dec_valid=1.
REQ-021 A write to register 0 SHALL still count as a hazard; register 0 is not hardwired.
REQ-022 stall SHALL be hazard & ~exe_flush & state==RUN; exe_flush has priority over stall.
REQ-023 issue SHALL be dec_valid & ~stall & ~exe_flush & state==RUN.
REQ-024 On issue, slot[0] SHALL load {1, dec_wr_en, dec_wr_sel}; otherwise it loads all-zeros.
REQ-025 exe_bubble SHALL equal ~issue.
REQ-026 ftch_dec_en SHALL equal state==RUN & ~stall & ~(issue & dec_halt).
REQ-027 ftch_dec_flush SHALL equal exe_flush & state==RUN.
REQ-028 All outputs except inflight, halt_done and err SHALL be combinational from inputs and state (zero latency).
REQ-029 FSM states SHALL be RUN, DRAIN and HALTED.
REQ-030 RUN->DRAIN on issue & dec_halt.
REQ-031 DRAIN->HALTED when every slot is invalid at the clock edge; in DRAIN there is no issue and ftch_dec_en=0.
REQ-032 HALTED SHALL be terminal until rst; in HALTED, halt_done=1, ftch_dec_en=0 and exe_bubble=1.
REQ-033 exe_flush=1 while in DRAIN or HALTED SHALL set err and be otherwise ignored.
REQ-034 inflight SHALL be registered and equal the number of valid slots after the edge.

Reset
REQ-035 rst SHALL clear all slots, set state to RUN, and set inflight=0, halt_done=0 and err=0, immediately and independently of clk.
REQ-036 rst asserted mid-stall or mid-drain SHALL discard all in-flight entries; the first cycle after release behaves as an empty pipeline.

Structure
REQ-037 FSM state encoding, slot record layout and the RF_BYPASS default SHALL live in the shared package pipe_pkg.
REQ-038 The scoreboard shift register with its match logic SHALL be a separate sub-module, hazard_sb.
REQ-039 The remaining FSM and output logic SHALL stay in pipe_hazard_ctrl.

Verification (DEPTH=3, RF_BYPASS=1)
REQ-040 ADD r1 issues at cycle 0, then SUB reading r1 sits in decode -> stall in cycles 1-2, issue in cycle 3, exe_bubble=1 in cycles 1-2.
REQ-041 Same producer/consumer pair with RF_BYPASS=0 -> 3 stall cycles.
REQ-042 exe_flush=1 while the decode instruction has a hazard -> ftch_dec_flush=1, stall=0, slot[0] receives a bubble, inflight drops by at most 1.
REQ-043 HALT issues with 2 older valid slots -> DRAIN for 3 cycles, then halt_done=1 held, ftch_dec_en=0.
REQ-044 exe_flush=1 during DRAIN -> err=1 and remains 1.
REQ-045 rst pulsed mid-stall with inflight=2 -> inflight=0 and stall=0 on the next cycle; the consumer issues immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the hazard controller: FSM state encoding, scoreboard slot
// record layout and the default register-file bypass setting.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam bit RF_BYPASS_DEFAULT = 1'b1;

   // Slot record is packed as {valid, wr_en, wr_sel[sel_w-1:0]}.
   function automatic int slot_width(input int sel_w);
      return sel_w + 2;
   endfunction

   function automatic int slot_valid_bit(input int sel_w);
      return sel_w + 1;
   endfunction

   function automatic int slot_wr_en_bit(input int sel_w);
      return sel_w;
   endfunction

endpackage

// File: rtl/hazard_sb.sv
// Scoreboard of in-flight register writers (execute .. writeback) and the
// read-after-write match against the decode-stage source registers.
module hazard_sb
   import pipe_pkg::*;
#(
   parameter int REG_SEL_W = 3,
   parameter int DEPTH     = 3,
   parameter int RF_BYPASS = int'(RF_BYPASS_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 shift_en,
   input  logic                 ins_valid,
   input  logic                 ins_wr_en,
   input  logic [REG_SEL_W-1:0] ins_wr_sel,
   input  logic                 dec_valid,
   input  logic [REG_SEL_W-1:0] rs_sel,
   input  logic                 rs_used,
   input  logic [REG_SEL_W-1:0] rt_sel,
   input  logic                 rt_used,
   output logic                 hazard,
   output logic [DEPTH-1:0]     nxt_valid
);

   localparam int SW  = slot_width(REG_SEL_W);
   localparam int VB  = slot_valid_bit(REG_SEL_W);
   localparam int WB  = slot_wr_en_bit(REG_SEL_W);
   // With a write-before-read register file the writeback slot never conflicts.
   localparam int CHK = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

   logic [SW-1:0]    slot_q [DEPTH];
   logic [SW-1:0]    slot_d [DEPTH];
   logic [DEPTH-1:0] match;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign slot_d[gi] = !shift_en ? slot_q[gi] :
                                ins_valid ? {1'b1, ins_wr_en, ins_wr_sel} : '0;
         end else begin : g_body
            assign slot_d[gi] = shift_en ? slot_q[gi-1] : slot_q[gi];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_q[gi] <= '0;
            end else begin
               slot_q[gi] <= slot_d[gi];
            end
         end

         if (gi < CHK) begin : g_chk
            assign match[gi] = slot_q[gi][VB] & slot_q[gi][WB] &
                               (((slot_q[gi][REG_SEL_W-1:0] == rs_sel) & rs_used) |
                                ((slot_q[gi][REG_SEL_W-1:0] == rt_sel) & rt_used));
         end else begin : g_nochk
            assign match[gi] = 1'b0;
         end

         assign nxt_valid[gi] = slot_d[gi][VB];
      end
   endgenerate

   assign hazard = dec_valid & (|match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls decode on RAW hazards, handles execute
// flushes and drains the pipeline after HALT.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_SEL_W = 3,
   parameter int DEPTH     = 3,
   parameter int RF_BYPASS = int'(RF_BYPASS_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dec_valid,
   input  logic [REG_SEL_W-1:0]       dec_rs_sel,
   input  logic [REG_SEL_W-1:0]       dec_rt_sel,
   input  logic                       dec_rs_used,
   input  logic                       dec_rt_used,
   input  logic                       dec_wr_en,
   input  logic [REG_SEL_W-1:0]       dec_wr_sel,
   input  logic                       dec_halt,
   input  logic                       exe_flush,
   output logic                       ftch_dec_en,
   output logic                       ftch_dec_flush,
   output logic                       exe_bubble,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic                       halt_done,
   output logic                       err
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic               halt_done_q, halt_done_d;
   logic               err_q, err_d;
   logic               hazard, stall, issue, in_run, shift_en;
   logic [DEPTH-1:0]   nxt_valid;

   hazard_sb #(
      .REG_SEL_W (REG_SEL_W),
      .DEPTH     (DEPTH),
      .RF_BYPASS (RF_BYPASS)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .shift_en   (shift_en),
      .ins_valid  (issue),
      .ins_wr_en  (dec_wr_en),
      .ins_wr_sel (dec_wr_sel),
      .dec_valid  (dec_valid),
      .rs_sel     (dec_rs_sel),
      .rs_used    (dec_rs_used),
      .rt_sel     (dec_rt_sel),
      .rt_used    (dec_rt_used),
      .hazard     (hazard),
      .nxt_valid  (nxt_valid)
   );

   always_comb begin
      inflight_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         inflight_d = inflight_d + CNT_W'(nxt_valid[i]);
      end
   end

   always_comb begin
      in_run         = (state_q == ST_RUN);
      shift_en       = (state_q != ST_HALTED);
      stall          = hazard & ~exe_flush & in_run;
      issue          = dec_valid & ~stall & ~exe_flush & in_run;
      ftch_dec_en    = in_run & ~stall & ~(issue & dec_halt);
      ftch_dec_flush = exe_flush & in_run;
      exe_bubble     = ~issue;
      err_d          = err_q | (exe_flush & ~in_run);
      state_d        = state_q;
      case (state_q)
         ST_RUN: begin
            if (issue & dec_halt) begin
               state_d = ST_DRAIN;
            end
         end
         // Leave DRAIN on the edge that empties the last slot.
         ST_DRAIN: begin
            if (inflight_d == '0) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
      halt_done_d = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         inflight_q  <= '0;
         halt_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         halt_done_q <= halt_done_d;
         err_q       <= err_d;
      end
   end

   assign inflight  = inflight_q;
   assign halt_done = halt_done_q;
   assign err       = err_q;

endmodule
